// File: rtl/m1_pkg.sv
// rtl/m1_pkg.sv - shared constants, state encoding and clip helper for the RGB writer
package m1_pkg;

    // Fixed-point (x65536) YUV->RGB coefficients
    localparam logic signed [31:0] C_Y  = 32'sd76284;
    localparam logic signed [31:0] C_RV = 32'sd104595;
    localparam logic signed [31:0] C_GU = 32'sd25624;
    localparam logic signed [31:0] C_GV = 32'sd53281;
    localparam logic signed [31:0] C_BU = 32'sd132251;

    localparam logic signed [8:0] Y_OFS  = 9'sd16;
    localparam logic signed [8:0] UV_OFS = 9'sd128;

    localparam int RGB_BASE_DEF  = 146944;
    localparam int NUM_PAIRS_DEF = 38400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_CALC_E,
        S_CALC_O,
        S_W0,
        S_W1,
        S_W2,
        S_DONE
    } csc_state_t;

    // Floor-shift the accumulator by 16 and saturate to an unsigned byte
    function automatic logic [7:0] clip8(input logic signed [31:0] acc);
        logic signed [31:0] sh;
        sh = acc >>> 16;
        if (sh[31])
            return 8'd0;
        else if (|sh[30:8])
            return 8'd255;
        else
            return sh[7:0];
    endfunction

endpackage

// File: rtl/csc_pixel.sv
// rtl/csc_pixel.sv - combinational YUV->RGB conversion of one pixel
// Ports: y/u/v in (8b each), r/g/b out (8b each, clipped to 0..255)
module csc_pixel
    import m1_pkg::*;
(
    input  logic [7:0] y,
    input  logic [7:0] u,
    input  logic [7:0] v,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    logic signed [8:0]  yp;
    logic signed [8:0]  up;
    logic signed [8:0]  vp;
    logic signed [31:0] yt;
    logic signed [31:0] r_acc;
    logic signed [31:0] g_acc;
    logic signed [31:0] b_acc;

    always_comb begin
        yp    = $signed({1'b0, y}) - Y_OFS;
        up    = $signed({1'b0, u}) - UV_OFS;
        vp    = $signed({1'b0, v}) - UV_OFS;
        yt    = C_Y * 32'(yp);
        r_acc = yt + C_RV * 32'(vp);
        g_acc = yt - C_GU * 32'(up) - C_GV * 32'(vp);
        b_acc = yt + C_BU * 32'(up);
        r     = clip8(r_acc);
        g     = clip8(g_acc);
        b     = clip8(b_acc);
    end

endmodule

// File: rtl/csc_rgb_writer.sv
// rtl/csc_rgb_writer.sv - converts YUV pixel pairs to RGB and writes 3 packed SRAM words per pair
// Ports: Clock_50/Resetn; start, busy, done frame control; in_valid/in_ready + in_{y,u,v}_{e,o} pair input;
//        wr_ready grant, sram_address/sram_write_data/sram_we_n write port
module csc_rgb_writer
    import m1_pkg::*;
#(
    parameter int RGB_BASE  = RGB_BASE_DEF,
    parameter int NUM_PAIRS = NUM_PAIRS_DEF
) (
    input  logic        Clock_50,
    input  logic        Resetn,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_y_e,
    input  logic [7:0]  in_y_o,
    input  logic [7:0]  in_u_e,
    input  logic [7:0]  in_u_o,
    input  logic [7:0]  in_v_e,
    input  logic [7:0]  in_v_o,
    input  logic        wr_ready,
    output logic [17:0] sram_address,
    output logic [15:0] sram_write_data,
    output logic        sram_we_n,
    output logic        busy,
    output logic        done
);

    localparam int              CW        = $clog2(NUM_PAIRS + 1);
    localparam logic [17:0]     BASE_A    = 18'(RGB_BASE);
    localparam logic [CW-1:0]   LAST_PAIR = CW'(NUM_PAIRS - 1);

    csc_state_t    state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [17:0]   addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   yuv_e_q, yuv_e_d;   // {y,u,v}
    logic [23:0]   yuv_o_q, yuv_o_d;
    logic [23:0]   rgb_e_q, rgb_e_d;   // {r,g,b}
    logic [23:0]   rgb_o_q, rgb_o_d;

    logic [23:0]   pix_in;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic          wr_fire;

    // One converter shared between the even (CALC_E) and odd (CALC_O) pixel
    assign pix_in = (state_q == S_CALC_O) ? yuv_o_q : yuv_e_q;

    csc_pixel u_pixel (
        .y (pix_in[23:16]),
        .u (pix_in[15:8]),
        .v (pix_in[7:0]),
        .r (pix_r),
        .g (pix_g),
        .b (pix_b)
    );

    // The write strobe must follow wr_ready in the same cycle, so it is the one unregistered output
    assign wr_fire   = wr_ready && (state_q == S_W0 || state_q == S_W1 || state_q == S_W2);
    assign sram_we_n = ~wr_fire;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        yuv_e_d = yuv_e_q;
        yuv_o_d = yuv_o_q;
        rgb_e_d = rgb_e_q;
        rgb_o_d = rgb_o_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_IN;
                    addr_d  = BASE_A;
                    cnt_d   = '0;
                end
            end
            S_WAIT_IN: begin
                if (in_valid && in_ready_q) begin
                    yuv_e_d = {in_y_e, in_u_e, in_v_e};
                    yuv_o_d = {in_y_o, in_u_o, in_v_o};
                    state_d = S_CALC_E;
                end
            end
            S_CALC_E: begin
                rgb_e_d = {pix_r, pix_g, pix_b};
                state_d = S_CALC_O;
            end
            S_CALC_O: begin
                rgb_o_d = {pix_r, pix_g, pix_b};
                data_d  = rgb_e_q[23:8];
                state_d = S_W0;
            end
            S_W0: begin
                if (wr_ready) begin
                    data_d  = {rgb_e_q[7:0], rgb_o_q[23:16]};
                    addr_d  = addr_q + 18'd1;
                    state_d = S_W1;
                end
            end
            S_W1: begin
                if (wr_ready) begin
                    data_d  = rgb_o_q[15:0];
                    addr_d  = addr_q + 18'd1;
                    state_d = S_W2;
                end
            end
            S_W2: begin
                if (wr_ready) begin
                    // Address is held on the frame's final word so it never steps past the region
                    if (cnt_q == LAST_PAIR) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = addr_q + 18'd1;
                        state_d = S_WAIT_IN;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_WAIT_IN);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= BASE_A;
            data_q     <= '0;
            cnt_q      <= '0;
            yuv_e_q    <= '0;
            yuv_o_q    <= '0;
            rgb_e_q    <= '0;
            rgb_o_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            yuv_e_q    <= yuv_e_d;
            yuv_o_q    <= yuv_o_d;
            rgb_e_q    <= rgb_e_d;
            rgb_o_q    <= rgb_o_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign sram_address    = addr_q;
    assign sram_write_data = data_q;

endmodule

// File: tb/tb_csc_rgb_writer.sv
// tb/tb_csc_rgb_writer.sv - scoreboard bench for csc_rgb_writer with hand-computed RGB words
module tb_csc_rgb_writer;

    localparam int TB_BASE  = 262138;   // last write of a 2-pair frame lands on 262143
    localparam int TB_PAIRS = 2;

    logic        clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_y_e = 8'd0, in_y_o = 8'd0, in_u_e = 8'd0, in_u_o = 8'd0, in_v_e = 8'd0, in_v_o = 8'd0;
    logic        wr_ready = 1'b1;
    logic [17:0] sram_address;
    logic [15:0] sram_write_data;
    logic        sram_we_n;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_idx = 0;
    logic [33:0] sb[$];

    csc_rgb_writer #(.RGB_BASE(TB_BASE), .NUM_PAIRS(TB_PAIRS)) dut (
        .Clock_50        (clk),
        .Resetn          (Resetn),
        .start           (start),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_y_e          (in_y_e),
        .in_y_o          (in_y_o),
        .in_u_e          (in_u_e),
        .in_u_o          (in_u_o),
        .in_v_e          (in_v_e),
        .in_v_o          (in_v_o),
        .wr_ready        (wr_ready),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_we_n       (sram_we_n),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one expected {address,data}
    always @(negedge clk) begin
        if (Resetn && !sram_we_n) begin
            check("we_n_needs_wr_ready", 32'(wr_ready), 32'd1);
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", sram_address, sram_write_data);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                check("wr_addr", 32'(sram_address), 32'(e[33:16]));
                check("wr_data", 32'(sram_write_data), 32'(e[15:0]));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic new_frame();
        exp_idx = 0;
        pulse_start();
    endtask

    task automatic send_pair(input logic [7:0] ye, ue, ve, yo, uo, vo,
                             input logic [15:0] w0, w1, w2);
        int waited;
        in_y_e = ye; in_u_e = ue; in_v_e = ve;
        in_y_o = yo; in_u_o = uo; in_v_o = vo;
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        sb.push_back({18'(TB_BASE + exp_idx),     w0});
        sb.push_back({18'(TB_BASE + exp_idx + 1), w1});
        sb.push_back({18'(TB_BASE + exp_idx + 2), w2});
        exp_idx += 3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_y_e = 8'($urandom); in_u_e = 8'($urandom); in_v_e = 8'($urandom);
        in_y_o = 8'($urandom); in_u_o = 8'($urandom); in_v_o = 8'($urandom);
    endtask

    task automatic wait_done(input bit start_in_done);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!done && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("last_addr_no_wrap", 32'(sram_address), 32'(TB_BASE + 3 * TB_PAIRS - 1));
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("still_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_addr", 32'(sram_address), 32'(TB_BASE));
        check("rst_data", 32'(sram_write_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        Resetn = 1'b1;
        @(posedge clk); #1;

        // Frame A: black pair, then white/clipped-white pair; a start mid-frame is ignored
        new_frame();
        send_pair(8'd16, 8'd128, 8'd128, 8'd16, 8'd128, 8'd128, 16'h0000, 16'h0000, 16'h0000);
        pulse_start();
        send_pair(8'd235, 8'd128, 8'd128, 8'd255, 8'd128, 8'd128, 16'hFEFE, 16'hFEFF, 16'hFFFF);
        wait_done(1'b0);

        // Frame B: floor/clip pair with a 4-cycle stall in W1, then a pixel-order sensitive pair
        new_frame();
        send_pair(8'd16, 8'd255, 8'd128, 8'd81, 8'd128, 8'd255, 16'h0000, 16'hFFFF, 16'h004B);
        repeat (3) @(posedge clk);
        #1;
        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_we_n", 32'(sram_we_n), 32'd1);
            check("stall_addr", 32'(sram_address), 32'(TB_BASE + 1));
            check("stall_data", 32'(sram_write_data), 32'h0000FFFF);
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        send_pair(8'd16, 8'd128, 8'd255, 8'd16, 8'd255, 8'd128, 16'hCA00, 16'h0000, 16'h00FF);
        wait_done(1'b1);

        // Frame C: reset right after W0 has been written
        new_frame();
        send_pair(8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 16'h8282, 16'h8282, 16'h8282);
        repeat (3) @(posedge clk);
        #1;
        Resetn = 1'b0;
        #1;
        check("rst_mid_we_n", 32'(sram_we_n), 32'd1);
        check("rst_mid_addr", 32'(sram_address), 32'(TB_BASE));
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        check("rst_mid_pending", 32'(sb.size()), 32'd2);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        Resetn = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("idle_after_reset", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Frame D: fresh frame restarts at the base address
        new_frame();
        send_pair(8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 16'h8282, 16'h8282, 16'h8282);
        send_pair(8'd235, 8'd128, 8'd128, 8'd255, 8'd128, 8'd128, 16'hFEFE, 16'hFEFF, 16'hFFFF);
        wait_done(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
